// File: rtl/z3_slave_engine.sv
// Zorro III slave cycle engine: synchronises the bus strobes, picks the lowest
// matching target and runs start / data / end phases with burst and timeout support.

module z3_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] pipe;

  // Idle level of every Zorro strobe is high, so the chain resets to 1.
  always_ff @(posedge clk) begin
    if (rst) pipe <= '1;
    else     pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];
endmodule

module z3_slave_engine #(
  parameter int                     NUM_TARGETS    = 4,
  parameter int                     SYNC_STAGES    = 2,
  parameter int                     TIMEOUT_CYCLES = 64,
  parameter logic [NUM_TARGETS-1:0] MTX_MASK       = NUM_TARGETS'(1)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FCS_n,
  input  logic [3:0]             DS_n,
  input  logic                   MTCR_n,
  input  logic                   READ,
  input  logic                   DOE,
  input  logic                   validspace,
  input  logic [NUM_TARGETS-1:0] match,
  input  logic [NUM_TARGETS-1:0] tgt_ack,
  output logic [NUM_TARGETS-1:0] tgt_sel,
  output logic                   tgt_start,
  output logic                   dtack,
  output logic                   MTACK_n,
  output logic                   timeout_err,
  output logic [7:0]             beat_count,
  output logic                   busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_MTX_WAIT} state_t;

  state_t                 state, nxt;
  logic [5:0]             async_in, sync_q;
  logic                   fcs_s, mtcr_s;
  logic [3:0]             ds_s;
  logic                   lockout, abort;
  logic [CW-1:0]          cnt;
  logic [NUM_TARGETS-1:0] pick;
  logic                   ds_any, ds_idle, ack_sel, mtx_ok, go, cnt_term;

  assign async_in = {MTCR_n, DS_n, FCS_n};

  for (genvar i = 0; i < 6; i++) begin : g_sync
    z3_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (CLK),
      .rst (RESET),
      .d   (async_in[i]),
      .q   (sync_q[i])
    );
  end

  assign fcs_s  = sync_q[0];
  assign ds_s   = sync_q[4:1];
  assign mtcr_s = sync_q[5];

  assign ds_any   = ~&ds_s;
  assign ds_idle  = &ds_s;
  assign ack_sel  = |(tgt_ack & tgt_sel);
  assign mtx_ok   = |(MTX_MASK & tgt_sel);
  assign go       = READ | (ds_any & DOE);
  assign cnt_term = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Lowest-index match wins.
  always_comb begin
    pick = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--)
      if (match[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      tgt_sel     <= '0;
      tgt_start   <= 1'b0;
      timeout_err <= 1'b0;
      beat_count  <= '0;
      busy        <= 1'b0;
      lockout     <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= nxt;
      busy        <= (nxt != S_IDLE);
      tgt_start   <= (nxt == S_DATA) && (state != S_DATA);
      timeout_err <= abort;

      // An abandoned or rejected cycle stays locked out until FCS is released.
      if (fcs_s)
        lockout <= 1'b0;
      else if ((state == S_IDLE && nxt == S_IDLE) || abort)
        lockout <= 1'b1;

      if (nxt == S_IDLE)
        tgt_sel <= '0;
      else if (state == S_IDLE) begin
        tgt_sel    <= pick;
        beat_count <= '0;
      end

      if (state == S_DATA && nxt == S_END && beat_count != 8'hFF)
        beat_count <= beat_count + 8'd1;

      if (nxt == S_DATA && state != S_DATA)
        cnt <= '0;
      else if (state == S_DATA)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt   = state;
    abort = 1'b0;
    case (state)
      S_IDLE:
        if (!fcs_s && !lockout && |match && validspace) nxt = S_START;
      S_START:
        if (fcs_s)   nxt = S_IDLE;
        else if (go) nxt = S_DATA;
      S_DATA:
        if (fcs_s)        nxt = S_IDLE;
        else if (ack_sel) nxt = S_END;
        else if (cnt_term) begin
          nxt   = S_IDLE;
          abort = 1'b1;
        end
      S_END:
        if (fcs_s)                            nxt = S_IDLE;
        else if (mtx_ok && !mtcr_s && ds_idle) nxt = S_MTX_WAIT;
      S_MTX_WAIT:
        if (fcs_s)              nxt = S_IDLE;
        else if (!mtcr_s && go) nxt = S_DATA;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dtack   = (state == S_END) && !fcs_s;
    MTACK_n = !((state != S_IDLE) && !fcs_s && mtx_ok);
  end
endmodule

// File: doc/z3_slave_engine.md
Name: z3_slave_engine

Overview:
- Parametrised Zorro III slave cycle engine for the card top level.
- Synchronises FCS_n, DS_n and MTCR_n, selects one of NUM_TARGETS address-matched targets, and sequences the start, data and end phases.
- Generates DTACK and MTACK_n.
- New relative to the existing slave FSM:
  - arbitrary target count with a priority encoder;
  - Zorro III multiple-transfer (burst) beats;
  - per-target burst enable;
  - configurable synchroniser depth;
  - a data-phase timeout that abandons a stuck cycle.

Parameters:
NUM_TARGETS, 4, number of decoded slave targets (1..16)
SYNC_STAGES, 2, synchroniser depth for FCS_n, DS_n and MTCR_n (2..4)
TIMEOUT_CYCLES, 64, CLK cycles allowed in DATA before abort (>=4)
MTX_MASK, 4'b0001, bit i=1 means target i accepts multiple-transfer beats (width NUM_TARGETS)

Ports:
CLK  input  1  card clock (25 MHz)
RESET  input  1  synchronous reset, active-high
FCS_n  input  1  Zorro full cycle strobe, asynchronous
DS_n  input  4  Zorro data strobes, asynchronous
MTCR_n  input  1  multiple-transfer cycle strobe, asynchronous
READ  input  1  Zorro read/write, 1 = read
DOE  input  1  Zorro data output enable
validspace  input  1  FC[1]^FC[0]
match  input  NUM_TARGETS  per-target address match, latched by the FCS address latch
tgt_ack  input  NUM_TARGETS  target i has completed its data phase (level)
tgt_sel  output  NUM_TARGETS  one-hot selected target, held from START until return to IDLE
tgt_start  output  1  one-cycle pulse at each beat start
dtack  output  1  drives the top-level DTACK_n open-drain
MTACK_n  output  1  multiple-transfer acknowledge, active-low
timeout_err  output  1  one-cycle pulse when a cycle is abandoned
beat_count  output  8  beats completed in the current cycle, saturating at 255
busy  output  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high, wins over every other input.
  - Synchroniser flops reset to 1; state = IDLE.
  - tgt_sel=0, tgt_start=0, dtack=0, MTACK_n=1, timeout_err=0, beat_count=0, busy=0.
  - The reset_lockout flag clears.
  - Reset asserted mid-cycle aborts the cycle; the outputs take these values on the next edge.
- Synchronisers: fcs_s, ds_s[3:0] and mtcr_s are the outputs of SYNC_STAGES-deep flop chains. All decisions use only the synchronised values. ds_any = any ds_s low.
- IDLE:
  - If fcs_s=0 and lockout=0:
    - if |match and validspace → START; tgt_sel = lowest-index set bit of match; beat_count=0;
    - otherwise set lockout=1 and stay in IDLE.
  - lockout clears when fcs_s=1, so a rejected cycle is never joined partway through.
- START:
  - fcs_s=1 → IDLE.
  - Else if READ=1, or (ds_any and DOE=1) → DATA. tgt_start=1 for exactly the first DATA cycle; the timeout counter clears.
- DATA:
  - fcs_s=1 → IDLE.
  - Else tgt_ack[sel]=1 → END.
  - Else if the counter reaches TIMEOUT_CYCLES-1 → IDLE with timeout_err pulse; dtack is never asserted for that cycle.
  - Otherwise the counter increments.
  - If ack and timeout terminal occur in the same cycle, ack wins.
- END:
  - dtack=1 while fcs_s=0; beat_count increments once on entry (saturating).
  - fcs_s=1 → IDLE; dtack=0 on the same edge.
  - If MTX_MASK[sel]=1, MTCR is active and ds_s all high with fcs_s=0 → MTX_WAIT; dtack deasserts.
- MTX_WAIT:
  - fcs_s=1 → IDLE.
  - mtcr_s=0 and (READ or (ds_any and DOE)) → DATA with a tgt_start pulse; the counter clears.
- MTACK_n:
  - Driven 0 while fcs_s=0, state is in {START, DATA, END, MTX_WAIT} and MTX_MASK[sel]=1.
  - Driven 1 otherwise, including for a target whose MTX_MASK bit is 0. The master then ends the burst with FCS.
- Priority inside any state: RESET > fcs_s deassert > ack > timeout.
- tgt_sel: changes only on the IDLE→START edge and clears on entry to IDLE.
- busy: a registered decode of state.

Test Plan:
- Single read, SYNC_STAGES=2:
  - Stimulus: match=4'b0100, validspace=1, FCS_n low at t0, READ=1, tgt_ack[2] high 3 cycles after tgt_start.
  - Required: tgt_sel=4'b0100; tgt_start a single-cycle pulse; dtack high until FCS_n high + 2 cycles; beat_count=1.
- Priority and rejection:
  - match=4'b1010 → tgt_sel=4'b0010.
  - match=0 with FCS_n low → stays IDLE with busy=0. Raising match mid-FCS must not start a cycle.
- Timeout:
  - Stimulus: write with DOE=1, DS_n=4'b0000, tgt_ack never asserts, TIMEOUT_CYCLES=64.
  - Required: timeout_err pulses exactly 64 cycles after DATA entry; dtack stays 0; state returns to IDLE.
- Burst, target 0 (MTX_MASK=1):
  - Stimulus: 4 beats toggling DS_n and MTCR_n with FCS_n held low.
  - Required: MTACK_n=0 throughout; 4 tgt_start pulses; beat_count=4; dtack deasserts between beats.
- Burst refused:
  - Stimulus: same burst stimulus to target 1 (MTX_MASK bit 1 = 0).
  - Required: MTACK_n=1; one beat only; engine waits in END until FCS_n rises.
- Reset mid-DATA:
  - Stimulus: RESET asserted for 1 cycle while in DATA.
  - Required: on the next edge all outputs at reset values, state IDLE. Releasing RESET while FCS_n is still low does not restart the cycle, because lockout is cleared by reset but fcs_s is still at its reset value of 1 for SYNC_STAGES cycles. Verify the engine starts only if match/validspace still hold at that point.
